mem_arbiter: RTL and testbench

//  Shares one mem_system (cache + backing memory) between instruction fetch (I port, read-only)
//  and data access (D port, load/store). Latches the granted request, holds mem_system Rd/Wr
//  and inputs stable until Done, then returns a one-cycle ack with read data to the owner.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_stat_cnt.sv | 25 ++
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the I/D memory arbiter.
// Statistics hardware is enabled by defining MEM_ARB_STATS_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D
   } arb_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_D_STREAK = 2;

   // The streak counter must hold values 0..n; never narrower than one bit.
   function automatic int streak_width(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mem_arbiter_stat_cnt.sv
// Cache hit/miss statistics: two wrapping 16-bit counters bumped on each completed access.
// Only instantiated when MEM_ARB_STATS_EN is defined.
module arb_stat_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        evt,
   input  logic        hit,
   output logic [15:0] hits,
   output logic [15:0] misses
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hits   <= 16'd0;
         misses <= 16'd0;
      end else if (evt) begin
         if (hit) begin
            hits <= hits + 16'd1;
         end else begin
            misses <= misses + 16'd1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one mem_system between the fetch (I) and data (D) ports.
// Define MEM_ARB_STATS_EN to add stat_hits/stat_misses counter outputs.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int D_STREAK = DEF_D_STREAK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_rd,
   output logic              m_wr,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_done,
   input  logic              m_hit,
   input  logic              m_err,
`ifdef MEM_ARB_STATS_EN
   output logic [15:0]       stat_hits,
   output logic [15:0]       stat_misses,
`endif
   output logic              err
);

   localparam int SW = streak_width(D_STREAK);
   localparam logic [SW-1:0] STREAK_MAX = SW'(D_STREAK);

   arb_state_t        state, stateNext;
   logic [SW-1:0]     streak, streakNext;
   logic              latchWr, latchWrNext;
   logic [ADDR_W-1:0] mAddrNext;
   logic [DATA_W-1:0] mWdataNext;
   logic              mRdNext, mWrNext;
   logic              iAckNext, dAckNext;
   logic [DATA_W-1:0] iRdataNext, dRdataNext;
   logic              errNext;
   owner_t            pick;
   logic              doneInGrant;

   // All outputs are registers; m_addr/m_wdata double as the request latches.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         streak  <= '0;
         latchWr <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_rd    <= 1'b0;
         m_wr    <= 1'b0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
         err     <= 1'b0;
      end else begin
         state   <= stateNext;
         streak  <= streakNext;
         latchWr <= latchWrNext;
         m_addr  <= mAddrNext;
         m_wdata <= mWdataNext;
         m_rd    <= mRdNext;
         m_wr    <= mWrNext;
         i_ack   <= iAckNext;
         d_ack   <= dAckNext;
         i_rdata <= iRdataNext;
         d_rdata <= dRdataNext;
         err     <= errNext;
      end
   end

   // I is forced only once D has won STREAK_MAX grants in a row while I was waiting.
   always_comb begin
      pick = (i_req && (!d_req || streak == STREAK_MAX)) ? OWN_I : OWN_D;
   end

   always_comb begin
      stateNext   = state;
      streakNext  = streak;
      latchWrNext = latchWr;
      mAddrNext   = m_addr;
      mWdataNext  = m_wdata;
      mRdNext     = m_rd;
      mWrNext     = m_wr;
      iAckNext    = 1'b0;
      dAckNext    = 1'b0;
      iRdataNext  = i_rdata;
      dRdataNext  = d_rdata;
      errNext     = err | m_err;
      doneInGrant = 1'b0;

      case (state)
         IDLE: begin
            mRdNext = 1'b0;
            mWrNext = 1'b0;
            if (m_done) begin
               errNext = 1'b1;
            end
            if (i_req || d_req) begin
               if (pick == OWN_I) begin
                  stateNext   = GRANT_I;
                  mAddrNext   = i_addr;
                  latchWrNext = 1'b0;
                  mRdNext     = 1'b1;
                  streakNext  = '0;
               end else begin
                  stateNext   = GRANT_D;
                  mAddrNext   = d_addr;
                  mWdataNext  = d_wdata;
                  latchWrNext = d_wr;
                  mRdNext     = !d_wr;
                  mWrNext     = d_wr;
                  if (!i_req) begin
                     streakNext = '0;
                  end else if (streak != STREAK_MAX) begin
                     streakNext = streak + SW'(1);
                  end
               end
            end
         end

         GRANT_I: begin
            if (m_done) begin
               doneInGrant = 1'b1;
               iAckNext    = 1'b1;
               iRdataNext  = m_rdata;
               mRdNext     = 1'b0;
               stateNext   = IDLE;
            end
         end

         GRANT_D: begin
            if (m_done) begin
               doneInGrant = 1'b1;
               dAckNext    = 1'b1;
               if (!latchWr) begin
                  dRdataNext = m_rdata;
               end
               mRdNext   = 1'b0;
               mWrNext   = 1'b0;
               stateNext = IDLE;
            end
         end

         default: begin
            stateNext = IDLE;
            mRdNext   = 1'b0;
            mWrNext   = 1'b0;
         end
      endcase
   end

`ifdef MEM_ARB_STATS_EN
   arb_stat_cnt statCnt (
      .clk    (clk),
      .rst    (rst),
      .evt    (doneInGrant),
      .hit    (m_hit),
      .hits   (stat_hits),
      .misses (stat_misses)
   );
`else
   // Hit information only feeds the statistics counters.
   logic unusedStatInputs;
   assign unusedStatInputs = &{1'b0, m_hit, doneInGrant};
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural mem_system (hit 1 cycle, miss 8 cycles)
// and queue-based requesters; data is checked against a reference memory updated at each ack.
module tb_mem_arbiter;

   localparam int D_STREAK = 2;
   localparam int MISS_LAT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0;
   logic [15:0] i_addr = '0;
   logic        i_ack;
   logic [15:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic        d_ack;
   logic [15:0] d_rdata;
   logic [15:0] m_addr;
   logic [15:0] m_wdata;
   logic        m_rd, m_wr;
   logic [15:0] m_rdata = '0;
   logic        m_done;
   logic        m_hit = 1'b0;
   logic        m_err = 1'b0;
   logic        err;
   logic        modelDone = 1'b0;
   logic        strayDone = 1'b0;
`ifdef MEM_ARB_STATS_EN
   logic [15:0] stat_hits, stat_misses;
`endif

   assign m_done = modelDone | strayDone;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .D_STREAK(D_STREAK)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_ack      (i_ack),
      .i_rdata    (i_rdata),
      .d_req      (d_req),
      .d_wr       (d_wr),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_ack      (d_ack),
      .d_rdata    (d_rdata),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_rd       (m_rd),
      .m_wr       (m_wr),
      .m_rdata    (m_rdata),
      .m_done     (m_done),
      .m_hit      (m_hit),
      .m_err      (m_err),
`ifdef MEM_ARB_STATS_EN
      .stat_hits  (stat_hits),
      .stat_misses(stat_misses),
`endif
      .err        (err)
   );

   int nVectors = 0;
   int nMiscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      if (obs !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Behavioural mem_system: backing store plus a set of cached addresses.
   bit [15:0] memArr [65536];
   bit        cached [65536];
   int        memCnt = 0;
   bit        memBusy = 1'b0;
   logic      lastHit = 1'b0;

   always @(posedge clk or negedge rst) begin : memModel
      bit fire;
      bit fireHit;
      fire = 1'b0;
      fireHit = 1'b0;
      if (!rst) begin
         modelDone <= 1'b0;
         memBusy   <= 1'b0;
         m_hit     <= 1'b0;
      end else begin
         modelDone <= 1'b0;
         if (modelDone) begin
            memBusy <= 1'b0;
         end else if (memBusy) begin
            if (memCnt == 0) fire = 1'b1;
            else memCnt <= memCnt - 1;
         end else if (m_rd || m_wr) begin
            if (cached[m_addr]) begin
               fire = 1'b1;
               fireHit = 1'b1;
            end else begin
               memBusy <= 1'b1;
               memCnt  <= MISS_LAT - 2;
            end
         end
         if (fire) begin
            modelDone <= 1'b1;
            memBusy   <= 1'b1;
            m_hit     <= fireHit;
            lastHit   <= fireHit;
            cached[m_addr] <= 1'b1;
            if (m_wr) memArr[m_addr] <= m_wdata;
            else m_rdata <= memArr[m_addr];
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic        wr;
      logic [15:0] addr;
      logic [15:0] data;
   } dTxn_t;

   logic [15:0] iQ [$];
   dTxn_t       dQ [$];
   bit [15:0]   refMem [65536];
   bit          ackLog [$];
   int          iAcks = 0, dAcks = 0, iPushed = 0, dPushed = 0;
   int          iReqCyc = 0, dReqCyc = 0, lastDLat = 0;
   logic [15:0] lastDRdata = '0, lastIRdata = '0;

   // Fetch requester: holds i_req until i_ack, then moves straight to the next queued address.
   always @(negedge clk or negedge rst) begin
      if (!rst) begin
         i_req = 1'b0;
         iQ.delete();
      end else begin
         if (i_ack) begin
            iAcks++;
            ackLog.push_back(1'b0);
            if (!i_req) begin
               checkOutput("i_ack_without_req", 32'd1, 32'd0);
            end else begin
               lastIRdata = i_rdata;
               checkOutput($sformatf("i_rdata@%04h", i_addr), i_rdata, refMem[i_addr]);
               i_req = 1'b0;
            end
         end
         if (!i_req && iQ.size() > 0) begin
            i_addr = iQ.pop_front();
            i_req = 1'b1;
            iReqCyc = cyc;
         end
      end
   end

   // Data requester: stores update the reference memory when acknowledged.
   always @(negedge clk or negedge rst) begin
      dTxn_t t;
      if (!rst) begin
         d_req = 1'b0;
         dQ.delete();
      end else begin
         if (d_ack) begin
            dAcks++;
            ackLog.push_back(1'b1);
            if (!d_req) begin
               checkOutput("d_ack_without_req", 32'd1, 32'd0);
            end else begin
               lastDLat = cyc - dReqCyc;
               if (d_wr) begin
                  refMem[d_addr] = d_wdata;
               end else begin
                  lastDRdata = d_rdata;
                  checkOutput($sformatf("d_rdata@%04h", d_addr), d_rdata, refMem[d_addr]);
               end
               d_req = 1'b0;
            end
         end
         if (!d_req && dQ.size() > 0) begin
            t = dQ.pop_front();
            d_wr = t.wr;
            d_addr = t.addr;
            d_wdata = t.data;
            d_req = 1'b1;
            dReqCyc = cyc;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && m_rd && m_wr) checkOutput("rd_wr_exclusive", 32'd1, 32'd0);
   end

   task automatic applyStimulus(input bit isD, input bit wr, input logic [15:0] addr,
                                input logic [15:0] data);
      dTxn_t t;
      if (isD) begin
         t.wr = wr;
         t.addr = addr;
         t.data = data;
         dQ.push_back(t);
         dPushed++;
      end else begin
         iQ.push_back(addr);
         iPushed++;
      end
   endtask

   task automatic applyReset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #4 rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic waitIdle(input string tag, input int bound);
      int n;
      n = 0;
      while ((iQ.size() > 0 || dQ.size() > 0 || i_req || d_req) && n < bound) begin
         @(posedge clk);
         n++;
      end
      if (n >= bound) checkOutput({tag, "_timeout"}, 32'd1, 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ctrl"}, {27'd0, i_ack, d_ack, m_rd, m_wr, err}, 32'd0);
      checkOutput({tag, "_maddr_wdata"}, {m_addr, m_wdata}, 32'd0);
      checkOutput({tag, "_rdata"}, {i_rdata, d_rdata}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int snap;
      int iBase, dBase;
      bit expD;

      applyReset();
      checkAllZero("reset");

      $display("[TB] reset during a D access");
      applyStimulus(1'b1, 1'b1, 16'h0200, 16'hABCD);
      n = 0;
      while (!m_wr && n < 50) begin
         @(posedge clk);
         n++;
      end
      checkOutput("grant_d_seen", {31'd0, m_wr}, 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 checkAllZero("reset_mid_grant");
      snap = dAcks;
      #2 rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("no_ack_after_abort", dAcks - snap, 32'd0);

      $display("[TB] store miss then load hit");
      applyStimulus(1'b1, 1'b1, 16'h015C, 16'h0018);
      waitIdle("store", 100);
      checkOutput("store_miss_latency", lastDLat, 32'd10);
      applyStimulus(1'b1, 1'b0, 16'h015C, 16'h0000);
      waitIdle("load", 100);
      checkOutput("load_hit_latency", lastDLat, 32'd3);
      checkOutput("load_hit_flag", {31'd0, lastHit}, 32'd1);
      checkOutput("load_data", lastDRdata, 32'h0018);

      $display("[TB] simultaneous I and D from IDLE");
      ackLog.delete();
      applyStimulus(1'b1, 1'b1, 16'h0000, 16'h5A5A);
      applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
      waitIdle("simul", 200);
      checkOutput("simul_acks", ackLog.size(), 32'd2);
      if (ackLog.size() == 2) begin
         checkOutput("simul_first_is_d", {31'd0, ackLog[0]}, 32'd1);
         checkOutput("simul_second_is_i", {31'd0, ackLog[1]}, 32'd0);
      end
      checkOutput("simul_i_rdata", lastIRdata, 32'h5A5A);

      $display("[TB] continuous D with pending I");
      ackLog.delete();
      for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 16'h0010 * k[15:0], 16'h0);
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b0, 16'h0100 + k[15:0], 16'h0);
      waitIdle("streak", 500);
      checkOutput("streak_acks", ackLog.size(), 32'd6);
      for (int k = 0; k < 6 && k < ackLog.size(); k++) begin
         expD = ((k + 1) % (D_STREAK + 1)) != 0;
         checkOutput($sformatf("streak_order_%0d", k), {31'd0, ackLog[k]}, {31'd0, expD});
      end

      $display("[TB] error reporting");
      checkOutput("err_clear_before", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1 strayDone = 1'b1;
      @(posedge clk);
      #1 strayDone = 1'b0;
      @(negedge clk);
      checkOutput("err_stray_done", {31'd0, err}, 32'd1);
      applyStimulus(1'b1, 1'b0, 16'h015C, 16'h0);
      waitIdle("err_access", 100);
      checkOutput("err_sticky", {31'd0, err}, 32'd1);
      applyReset();
      checkOutput("err_cleared_by_reset", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1 m_err = 1'b1;
      @(posedge clk);
      #1 m_err = 1'b0;
      @(negedge clk);
      checkOutput("err_m_err", {31'd0, err}, 32'd1);
      applyReset();

`ifdef MEM_ARB_STATS_EN
      $display("[TB] statistics counters");
      checkOutput("stats_reset", {stat_hits, stat_misses}, 32'd0);
      applyStimulus(1'b1, 1'b1, 16'h0300, 16'h7777);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 16'h0300, 16'h0);
      waitIdle("stats", 300);
      checkOutput("stat_misses", {16'd0, stat_misses}, 32'd1);
      checkOutput("stat_hits", {16'd0, stat_hits}, 32'd3);
`endif

      $display("[TB] randomized traffic");
      iBase = iAcks - iPushed;
      dBase = dAcks - dPushed;
      for (int k = 0; k < 80; k++) begin
         int sel;
         logic [15:0] a, w;
         sel = $urandom_range(0, 2);
         a = 16'($urandom_range(0, 11)) << 4;
         w = 16'($urandom);
         if (sel != 1) applyStimulus(1'b1, 1'($urandom_range(0, 1)), a, w);
         if (sel != 0) applyStimulus(1'b0, 1'b0, 16'($urandom_range(0, 11)) << 4, 16'h0);
         repeat ($urandom_range(0, 6)) @(posedge clk);
         #1;
      end
      waitIdle("random", 20000);
      checkOutput("random_i_acks", iAcks - iBase, iPushed);
      checkOutput("random_d_acks", dAcks - dBase, dPushed);
      checkOutput("random_err", {31'd0, err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
